// File: rtl/islemci_pkg.sv
// Shared definitions for the multicycle RV32 core: reset PC, bus widths,
// control-flow opcodes and the instruction+PC entry carried by the fetch buffer.
package islemci_pkg;

  localparam logic [31:0] BELLEK_ADRES = 32'h8000_0000;
  localparam int          VERI_BIT     = 32;
  localparam int          ADRES_BIT    = 32;

  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;

  typedef struct packed {
    logic [VERI_BIT-1:0]  veri;
    logic [ADRES_BIT-1:0] ps;
  } buyruk_t;

  // True for the opcodes that may later drive yonlendir from execute.
  function automatic logic akis_degistiren_mi(input logic [VERI_BIT-1:0] b);
    return (b[6:0] == OP_BRANCH) || (b[6:0] == OP_JAL) || (b[6:0] == OP_JALR);
  endfunction

endpackage

// File: rtl/buyruk_getirici_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface buyruk_getirici_if #(
  parameter int VERI_BIT  = islemci_pkg::VERI_BIT,
  parameter int ADRES_BIT = islemci_pkg::ADRES_BIT
);

  logic                 istek_gecerli;
  logic [ADRES_BIT-1:0] istek_adres;
  logic                 istek_hazir;
  logic                 yanit_gecerli;
  logic [VERI_BIT-1:0]  yanit_veri;
  logic                 buyruk_gecerli;
  logic [VERI_BIT-1:0]  buyruk;
  logic [ADRES_BIT-1:0] buyruk_ps;
  logic                 buyruk_hazir;

  modport master (
    output istek_gecerli, istek_adres, buyruk_gecerli, buyruk, buyruk_ps,
    input  istek_hazir, yanit_gecerli, yanit_veri, buyruk_hazir
  );

  modport slave (
    input  istek_gecerli, istek_adres, buyruk_gecerli, buyruk, buyruk_ps,
    output istek_hazir, yanit_gecerli, yanit_veri, buyruk_hazir
  );

endinterface

// File: rtl/buyruk_fifo.sv
// Instruction buffer: synchronous FIFO of {instruction, PC} entries with a
// single-cycle flush. Head is read straight from storage; there is no bypass.
module buyruk_fifo
  import islemci_pkg::*;
#(
  parameter int FIFO_DERINLIK = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  buyruk_t                          push_data,
  input  logic                             pop,
  output buyruk_t                          head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DERINLIK):0]   count
);

  localparam int IW = $clog2(FIFO_DERINLIK);
  localparam int CW = IW + 1;

  buyruk_t        mem [FIFO_DERINLIK];
  logic [IW-1:0]  wr_ptr;
  logic [IW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DERINLIK));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + IW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + IW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried by count alone,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/buyruk_getirici.sv
// Instruction fetch front-end: credit-limited word fetch, in-order response
// tagging with PC, and redirect handling that drops stale in-flight responses.
module buyruk_getirici #(
  parameter logic [31:0] BELLEK_ADRES  = islemci_pkg::BELLEK_ADRES,
  parameter int          VERI_BIT      = islemci_pkg::VERI_BIT,
  parameter int          ADRES_BIT     = islemci_pkg::ADRES_BIT,
  parameter int          FIFO_DERINLIK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  buyruk_getirici_if.master     bus,
  input  logic                  yonlendir,
  input  logic [ADRES_BIT-1:0]  yonlendir_adres,
  output logic                  hizasiz
);

  import islemci_pkg::buyruk_t;

  localparam int CW = $clog2(FIFO_DERINLIK) + 1;

  logic [ADRES_BIT-1:0] fetch_ps;
  logic [ADRES_BIT-1:0] yanit_ps;
  logic [ADRES_BIT-1:0] hedef;
  logic [CW-1:0]        bekleyen;
  logic [CW-1:0]        atilacak;
  logic [CW-1:0]        doluluk;
  logic [CW+1:0]        toplam;
  logic [VERI_BIT-1:0]  gelen_veri;
  logic                 istek_el;
  logic                 yanit_etkin;
  logic                 yanit_sakla;
  logic                 fifo_full;
  logic                 fifo_empty;
  buyruk_t              giris;
  buyruk_t              bas;

  // Every buffer slot is promised to exactly one entry: stored, in flight, or to be dropped.
  assign toplam = (CW+2)'(doluluk) + (CW+2)'(bekleyen) + (CW+2)'(atilacak);

  // NOTE: request valid is combinational on yonlendir so a redirect cycle can
  // never launch a request from the stale PC.
  assign bus.istek_gecerli = (toplam < (CW+2)'(FIFO_DERINLIK)) && !yonlendir && !rst;
  assign bus.istek_adres   = fetch_ps;

  assign istek_el    = bus.istek_gecerli && bus.istek_hazir;
  assign yanit_etkin = bus.yanit_gecerli && ((bekleyen != '0) || (atilacak != '0));
  assign yanit_sakla = yanit_etkin && (atilacak == '0) && !yonlendir && !fifo_full;
  assign hedef       = {yonlendir_adres[ADRES_BIT-1:2], 2'b00};

  assign gelen_veri  = bus.yanit_veri;
  assign giris.veri  = gelen_veri;
  assign giris.ps    = yanit_ps;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ps <= ADRES_BIT'(BELLEK_ADRES);
      yanit_ps <= ADRES_BIT'(BELLEK_ADRES);
      bekleyen <= '0;
      atilacak <= '0;
      hizasiz  <= 1'b0;
    end else if (yonlendir) begin
      // All outstanding responses become drops; one arriving now is already spent.
      atilacak <= atilacak + bekleyen - CW'(yanit_etkin);
      bekleyen <= '0;
      fetch_ps <= hedef;
      yanit_ps <= hedef;
      hizasiz  <= |yonlendir_adres[1:0];
    end else begin
      hizasiz <= 1'b0;
      if (istek_el) fetch_ps <= fetch_ps + ADRES_BIT'(4);
      // Older drops always precede kept responses in the in-order stream.
      if (yanit_etkin && (atilacak != '0)) begin
        atilacak <= atilacak - CW'(1);
        bekleyen <= bekleyen + CW'(istek_el);
      end else begin
        bekleyen <= bekleyen + CW'(istek_el) - CW'(yanit_etkin);
        if (yanit_etkin) yanit_ps <= yanit_ps + ADRES_BIT'(4);
      end
    end
  end

  buyruk_fifo #(
    .FIFO_DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (yonlendir),
    .push      (yanit_sakla),
    .push_data (giris),
    .pop       (bus.buyruk_gecerli && bus.buyruk_hazir),
    .head      (bas),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (doluluk)
  );

  assign bus.buyruk_gecerli = !fifo_empty;
  assign bus.buyruk         = bas.veri;
  assign bus.buyruk_ps      = bas.ps;

endmodule
